// File: rtl/rename_regfile.sv
// Architectural register file merged with a per-register rename status table
// (busy bit + producing ROB tag), with N combinational source ports and a commit port.
module rename_regfile #(
    parameter  int XLEN  = 32,
    parameter  int NREG  = 32,
    parameter  int ROB_W = 4,
    parameter  int NSRC  = 2,
    localparam int RW    = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    // Operand protocol: there is no stall; is_src_val[i] carries data only when
    // is_src_rdy[i]=1 (otherwise 0), and issue must then wait on is_src_tag[i].
    input  logic [NSRC*RW-1:0]    is_src,
    output logic [NSRC*XLEN-1:0]  is_src_val,
    output logic [NSRC-1:0]       is_src_rdy,
    output logic [NSRC*ROB_W-1:0] is_src_tag,
    input  logic                  is_ren_en,
    input  logic [RW-1:0]         is_ren_rd,
    input  logic [ROB_W-1:0]      is_ren_tag,
    output logic [NSRC*ROB_W-1:0] rob_qtag,
    input  logic [NSRC-1:0]       rob_qrdy,
    input  logic [NSRC*XLEN-1:0]  rob_qval,
    input  logic                  cm_en,
    input  logic [RW-1:0]         cm_rd,
    input  logic [XLEN-1:0]       cm_val,
    input  logic [ROB_W-1:0]      cm_tag,
    input  logic                  flush,
    output logic [NREG-1:0]       busy_vec
);

    logic [XLEN-1:0]  regs [NREG];
    logic [ROB_W-1:0] tags [NREG];
    logic [NREG-1:0]  busy;

    logic cm_wr;
    logic cm_clr;
    logic ren_wr;

    // x0 is never written nor renamed, so its entry stays at its reset value.
    assign cm_wr  = cm_en && (cm_rd != '0);
    assign cm_clr = cm_wr && busy[cm_rd] && (tags[cm_rd] == cm_tag);
    assign ren_wr = is_ren_en && (is_ren_rd != '0) && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
                tags[r] <= '0;
            end
        end else if (rdy) begin
            if (cm_wr) begin
                regs[cm_rd] <= cm_val;
            end
            if (flush) begin
                busy <= '0;
            end else begin
                if (cm_clr) begin
                    busy[cm_rd] <= 1'b0;
                end
                // Rename is applied after the commit clear so it wins on the same register.
                if (ren_wr) begin
                    busy[is_ren_rd] <= 1'b1;
                    tags[is_ren_rd] <= is_ren_tag;
                end
            end
        end
    end

    assign busy_vec = busy;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        logic [RW-1:0]    s;
        logic [ROB_W-1:0] t;
        logic             cm_hit;
        logic [XLEN-1:0]  val;
        logic             ok;

        assign s      = is_src[g*RW +: RW];
        assign t      = tags[s];
        assign cm_hit = cm_en && (cm_rd == s) && (cm_tag == t);

        always_comb begin
            val = '0;
            ok  = 1'b0;
            if (s == '0) begin
                ok = 1'b1;
            end else if (!busy[s]) begin
                val = regs[s];
                ok  = 1'b1;
            end else if (cm_hit) begin
                val = cm_val;
                ok  = 1'b1;
            end else if (rob_qrdy[g]) begin
                val = rob_qval[g*XLEN +: XLEN];
                ok  = 1'b1;
            end
        end

        assign is_src_val[g*XLEN +: XLEN]  = val;
        assign is_src_rdy[g]               = ok;
        assign is_src_tag[g*ROB_W +: ROB_W] = t;
        assign rob_qtag[g*ROB_W +: ROB_W]   = t;
    end

endmodule

// File: tb/tb_rename_regfile.sv
// Directed bench for rename_regfile: a table of combinational read vectors over a
// prepared state, plus hand-written multi-cycle rename/commit/flush sequences.
module tb_rename_regfile;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int ROB_W = 4;
    localparam int NSRC  = 2;
    localparam int RW    = 5;

    logic                  clk;
    logic                  rst;
    logic                  rdy;
    logic [NSRC*RW-1:0]    is_src;
    logic [NSRC*XLEN-1:0]  is_src_val;
    logic [NSRC-1:0]       is_src_rdy;
    logic [NSRC*ROB_W-1:0] is_src_tag;
    logic                  is_ren_en;
    logic [RW-1:0]         is_ren_rd;
    logic [ROB_W-1:0]      is_ren_tag;
    logic [NSRC*ROB_W-1:0] rob_qtag;
    logic [NSRC-1:0]       rob_qrdy;
    logic [NSRC*XLEN-1:0]  rob_qval;
    logic                  cm_en;
    logic [RW-1:0]         cm_rd;
    logic [XLEN-1:0]       cm_val;
    logic [ROB_W-1:0]      cm_tag;
    logic                  flush;
    logic [NREG-1:0]       busy_vec;

    int n_cmp = 0;
    int n_err = 0;

    rename_regfile #(.XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W), .NSRC(NSRC)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .is_src(is_src), .is_src_val(is_src_val), .is_src_rdy(is_src_rdy),
        .is_src_tag(is_src_tag),
        .is_ren_en(is_ren_en), .is_ren_rd(is_ren_rd), .is_ren_tag(is_ren_tag),
        .rob_qtag(rob_qtag), .rob_qrdy(rob_qrdy), .rob_qval(rob_qval),
        .cm_en(cm_en), .cm_rd(cm_rd), .cm_val(cm_val), .cm_tag(cm_tag),
        .flush(flush), .busy_vec(busy_vec)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  s0, s1;
        logic [1:0]  qrdy;
        logic [31:0] qv0, qv1;
        logic        cm_en;
        logic [4:0]  cm_rd;
        logic [3:0]  cm_tag;
        logic [31:0] cm_val;
        logic [1:0]  exp_rdy;
        logic [31:0] exp_v0, exp_v1;
        logic [3:0]  exp_t0, exp_t1;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rdy = 1'b1; is_src = '0;
        is_ren_en = 1'b0; is_ren_rd = '0; is_ren_tag = '0;
        rob_qrdy = '0; rob_qval = '0;
        cm_en = 1'b0; cm_rd = '0; cm_val = '0; cm_tag = '0;
        flush = 1'b0;
    endtask

    task automatic do_rename(input logic [4:0] rd, input logic [3:0] tag);
        idle();
        is_ren_en = 1'b1; is_ren_rd = rd; is_ren_tag = tag;
        step();
        idle();
    endtask

    task automatic do_commit(input logic [4:0] rd, input logic [31:0] val, input logic [3:0] tag);
        idle();
        cm_en = 1'b1; cm_rd = rd; cm_val = val; cm_tag = tag;
        step();
        idle();
    endtask

    task automatic read2(input logic [4:0] s0, input logic [4:0] s1);
        is_src = {s1, s0};
        #1;
    endtask

    initial begin
        vecs[0] = '{5'd5, 5'd0, 2'b00, 32'h0, 32'h0, 1'b0, 5'd0, 4'd0, 32'h0,
                    2'b11, 32'h500, 32'h0, 4'd0, 4'd0};
        vecs[1] = '{5'd3, 5'd10, 2'b00, 32'h0, 32'h0, 1'b0, 5'd0, 4'd0, 32'h0,
                    2'b00, 32'h0, 32'h0, 4'd7, 4'd12};
        vecs[2] = '{5'd3, 5'd10, 2'b01, 32'h55, 32'h66, 1'b0, 5'd0, 4'd0, 32'h0,
                    2'b01, 32'h55, 32'h0, 4'd7, 4'd12};
        vecs[3] = '{5'd3, 5'd10, 2'b00, 32'h0, 32'h0, 1'b1, 5'd3, 4'd7, 32'h1234,
                    2'b01, 32'h1234, 32'h0, 4'd7, 4'd12};
        vecs[4] = '{5'd3, 5'd10, 2'b10, 32'h0, 32'h66, 1'b1, 5'd3, 4'd6, 32'h1234,
                    2'b10, 32'h0, 32'h66, 4'd7, 4'd12};
        vecs[5] = '{5'd0, 5'd5, 2'b11, 32'h11, 32'h22, 1'b1, 5'd5, 4'd0, 32'h999,
                    2'b11, 32'h0, 32'h500, 4'd0, 4'd0};
        vecs[6] = '{5'd10, 5'd3, 2'b11, 32'hAA, 32'hBB, 1'b1, 5'd10, 4'd12, 32'hCC,
                    2'b11, 32'hCC, 32'hBB, 4'd12, 4'd7};

        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // reset state
        check("reset_busy_vec", 64'(busy_vec), 64'h0);
        read2(5'd5, 5'd0);
        check("reset_rdy", 64'(is_src_rdy), 64'h3);
        check("reset_val", 64'(is_src_val), 64'h0);
        do_commit(5'd0, 32'hDEAD, 4'd0);
        read2(5'd0, 5'd0);
        check("x0_after_commit", 64'(is_src_val[31:0]), 64'h0);
        check("x0_busy_after_commit", 64'(busy_vec), 64'h0);

        // prepared state: x5=0x500, x3 busy tag 7, x10 busy tag 12
        idle();
        cm_en = 1'b1; cm_rd = 5'd5; cm_val = 32'h500; cm_tag = 4'd0;
        is_ren_en = 1'b1; is_ren_rd = 5'd3; is_ren_tag = 4'd7;
        step();
        do_rename(5'd10, 4'd12);
        check("setup_busy_vec", 64'(busy_vec), 64'h408);

        // combinational read table; rdy held low so no state moves meanwhile
        for (int i = 0; i < 7; i++) begin
            idle();
            rdy      = 1'b0;
            is_src   = {vecs[i].s1, vecs[i].s0};
            rob_qrdy = vecs[i].qrdy;
            rob_qval = {vecs[i].qv1, vecs[i].qv0};
            cm_en    = vecs[i].cm_en;
            cm_rd    = vecs[i].cm_rd;
            cm_tag   = vecs[i].cm_tag;
            cm_val   = vecs[i].cm_val;
            #1;
            check($sformatf("vec%0d_rdy", i), 64'(is_src_rdy), 64'(vecs[i].exp_rdy));
            check($sformatf("vec%0d_val0", i), 64'(is_src_val[31:0]), 64'(vecs[i].exp_v0));
            check($sformatf("vec%0d_val1", i), 64'(is_src_val[63:32]), 64'(vecs[i].exp_v1));
            check($sformatf("vec%0d_tag", i), 64'(is_src_tag), 64'({vecs[i].exp_t1, vecs[i].exp_t0}));
            check($sformatf("vec%0d_qtag", i), 64'(rob_qtag), 64'({vecs[i].exp_t1, vecs[i].exp_t0}));
        end
        idle();
        check("table_no_state_change", 64'(busy_vec), 64'h408);

        // commit clears busy of x3 and writes the value
        do_commit(5'd3, 32'h1234, 4'd7);
        read2(5'd3, 5'd0);
        check("commit_clears_busy", 64'(busy_vec), 64'h400);
        check("commit_read_rdy", 64'(is_src_rdy[0]), 64'h1);
        check("commit_read_val", 64'(is_src_val[31:0]), 64'h1234);

        // stale commit writes value but keeps newer rename
        do_rename(5'd4, 4'd2);
        do_rename(5'd4, 4'd5);
        do_commit(5'd4, 32'h9, 4'd2);
        read2(5'd4, 5'd0);
        check("stale_commit_busy", 64'(busy_vec[4]), 64'h1);
        check("stale_commit_tag", 64'(is_src_tag[3:0]), 64'h5);
        check("stale_commit_rdy", 64'(is_src_rdy[0]), 64'h0);
        do_commit(5'd4, 32'hA, 4'd5);
        read2(5'd4, 5'd0);
        check("final_commit_busy", 64'(busy_vec[4]), 64'h0);
        check("final_commit_val", 64'(is_src_val[31:0]), 64'hA);

        // same-cycle rename and commit on x6
        do_rename(5'd6, 4'd3);
        idle();
        is_ren_en = 1'b1; is_ren_rd = 5'd6; is_ren_tag = 4'd1;
        cm_en = 1'b1; cm_rd = 5'd6; cm_val = 32'h77; cm_tag = 4'd3;
        step();
        idle();
        read2(5'd6, 5'd0);
        check("ren_cm_busy", 64'(busy_vec[6]), 64'h1);
        check("ren_cm_tag", 64'(is_src_tag[3:0]), 64'h1);

        // flush with a dropped rename and a committed value
        do_rename(5'd1, 4'd4);
        do_rename(5'd2, 4'd5);
        do_rename(5'd9, 4'd6);
        check("pre_flush_busy", 64'(busy_vec), 64'h646);
        idle();
        flush = 1'b1;
        is_ren_en = 1'b1; is_ren_rd = 5'd8; is_ren_tag = 4'd8;
        cm_en = 1'b1; cm_rd = 5'd1; cm_val = 32'h42; cm_tag = 4'd4;
        step();
        idle();
        check("flush_busy_vec", 64'(busy_vec), 64'h0);
        read2(5'd1, 5'd6);
        check("flush_rdy", 64'(is_src_rdy), 64'h3);
        check("flush_x1_val", 64'(is_src_val[31:0]), 64'h42);
        check("flush_x6_val", 64'(is_src_val[63:32]), 64'h77);

        // rdy low freezes state
        idle();
        rdy = 1'b0;
        is_ren_en = 1'b1; is_ren_rd = 5'd7; is_ren_tag = 4'd3;
        cm_en = 1'b1; cm_rd = 5'd5; cm_val = 32'hBAD; cm_tag = 4'd0;
        step();
        idle();
        check("hold_busy_vec", 64'(busy_vec), 64'h0);
        read2(5'd5, 5'd7);
        check("hold_x5_val", 64'(is_src_val[31:0]), 64'h500);
        check("hold_x7_val", 64'(is_src_val[63:32]), 64'h0);

        // reset overrides rdy=0
        do_rename(5'd2, 4'd9);
        check("pre_reset_busy", 64'(busy_vec), 64'h4);
        idle();
        rdy = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        check("reset2_busy_vec", 64'(busy_vec), 64'h0);
        read2(5'd5, 5'd1);
        check("reset2_val", 64'(is_src_val), 64'h0);
        check("reset2_rdy", 64'(is_src_rdy), 64'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rename_regfile.md
Name: rename_regfile

Overview:
- Architectural register file merged with a per-register rename status table (busy bit and ROB tag), parametrised in data width, register count, ROB tag width and number of source read ports.
- Sits between the issue stage and the ROB. Issue reads source operands and renames a destination. The ROB supplies in-flight values for busy sources and retires results through a commit port.
- Features not in the previous generation:
  - x0 is hardwired.
  - Commit is bypassed to same-cycle reads.
  - Committed values are always written.
  - Global flush on mispredict.
  - N source ports.
  - Busy-vector status output.

Parameters:
- XLEN, 32, data width.
- NREG, 32, number of architectural registers (power of 2, at least 2). Localparam RW = $clog2(NREG).
- ROB_W, 4, ROB tag width.
- NSRC, 2, number of source read ports. Port i occupies bits [i*W +: W] of each flattened bus.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; when low, all state holds
- is_src  in  NSRC*RW  source register indices
- is_src_val  out  NSRC*XLEN  operand value, valid when the matching is_src_rdy bit is 1, else 0
- is_src_rdy  out  NSRC  operand available this cycle
- is_src_tag  out  NSRC*ROB_W  producer ROB tag, meaningful when is_src_rdy=0
- is_ren_en  in  1  rename destination this cycle
- is_ren_rd  in  RW  destination register
- is_ren_tag  in  ROB_W  ROB entry allocated to the destination
- rob_qtag  out  NSRC*ROB_W  ROB lookup tag per source; equals the stored tag of is_src[i]
- rob_qrdy  in  NSRC  ROB entry for rob_qtag[i] has its result
- rob_qval  in  NSRC*XLEN  that result
- cm_en  in  1  commit valid
- cm_rd  in  RW  commit destination
- cm_val  in  XLEN  commit value
- cm_tag  in  ROB_W  committing ROB tag
- flush  in  1  mispredict flush
- busy_vec  out  NREG  registered busy bits; bit 0 always 0

Behaviour:
- Reset (rst=1 at posedge): all values 0, all busy 0, all tags 0. Outputs follow combinationally: busy_vec=0, every is_src_rdy=1, every is_src_val=0. Reset overrides rdy, flush, rename and commit.
- Read path (combinational, zero latency). Per port i with s=is_src[i], priority order:
  1. s==0: val=0, rdy=1.
  2. !busy[s]: val=reg[s], rdy=1.
  3. cm_en && cm_rd==s && cm_tag==tag[s]: val=cm_val, rdy=1 (commit bypass).
  4. rob_qrdy[i]: val=rob_qval[i], rdy=1.
  5. Otherwise: val=0, rdy=0.
- is_src_tag[i] = tag[s] in all cases. Read outputs ignore same-cycle rename (issue orders its own intra-bundle dependencies).
- Sequential update, only when rdy=1 and rst=0. Commit:
  - If cm_en and cm_rd!=0: reg[cm_rd] <= cm_val unconditionally. This is the architectural write.
  - Busy clears only if busy[cm_rd] and tag[cm_rd]==cm_tag.
- Sequential update, rename:
  - If is_ren_en and is_ren_rd!=0 and !flush: busy[rd] <= 1, tag[rd] <= is_ren_tag.
  - Rename to x0 is ignored.
- Same-cycle rename and commit to the same register: rename wins for busy and tag; the commit value is still written.
- Flush: all busy bits <= 0 (tags may keep stale values); same-cycle rename is dropped; same-cycle commit value is still written. Flush does not affect the same-cycle combinational read outputs.
- rdy=0: no state change. Read outputs stay combinationally valid.
- Tag wrap-around needs no special handling: the ROB guarantees a tag is not reused while older uses are outstanding.

Test Plan:
- Reset then read x5,x0 -> rdy=11, vals 0,0, busy_vec=0. Commit cm_rd=0 val 0xDEAD -> x0 still reads 0.
- Rename x3->tag 7; next cycle read x3 with rob_qrdy=0 -> rdy=0, tag=7, rob_qtag=7. With rob_qrdy=1, rob_qval=0x55 -> rdy=1, val=0x55.
- x3 busy tag 7; in one cycle drive cm_en, rd=3, tag 7, val 0x1234 and read x3 -> same-cycle rdy=1, val 0x1234. Next cycle busy_vec[3]=0, reg reads 0x1234.
- Rename x4->tag 2, then x4->tag 5. Commit rd 4 tag 2 val 0x9 -> busy[4] stays 1 with tag 5, reg[4]=0x9. Commit tag 5 val 0xA -> busy clears, reads 0xA.
- Same cycle: rename x6->tag 1 and commit x6 (matching old tag 3) val 0x77 -> busy[6]=1, tag 1, reg[6]=0x77.
- Busy x1,x2,x9, then flush with rename x8 and commit x1 val 0x42 -> busy_vec=0, x8 not busy, x1 reads 0x42. rdy=0 with rename x7 -> no change.
